// File: rtl/text_screen_writer.sv
// Turns the keyboard command stream into character RAM writes. It tracks the cursor and
// scrolls the screen by rotating the top row and blanking the row that is reused.
module text_screen_writer #(
   parameter int unsigned COLS        = 80,
   parameter int unsigned ROWS        = 30,
   parameter int unsigned COL_W       = 7,
   parameter int unsigned ROW_W       = 5,
   parameter int unsigned ADDR_W      = 12,
   parameter logic [7:0]  CLEAR_COLOR = 8'h07
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [7:0]        ASCII_IN,
   input  logic [7:0]        COLOR_IN,
   input  logic [1:0]        COMMAND_IN,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [15:0]       WR_DATA,
   output logic [ROW_W-1:0]  CURSOR_ROW,
   output logic [COL_W-1:0]  CURSOR_COL,
   output logic [ROW_W-1:0]  TOP_ROW,
   output logic              BUSY,
   output logic              DROP
);

   localparam int unsigned CELLS = COLS * ROWS;
   localparam logic [1:0] CMD_DISP = 2'b00;
   localparam logic [1:0] CMD_DEL  = 2'b01;
   localparam logic [1:0] CMD_NL   = 2'b10;
   localparam logic [1:0] CMD_NULL = 2'b11;
   localparam logic [15:0] BLANK = {CLEAR_COLOR, 8'h20};

   typedef enum logic [1:0] {StInit, StIdle, StClrRow} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0]  clr_base_q, clr_base_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   top_q, top_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [15:0]        wr_data_q, wr_data_d;
   logic               busy_q, busy_d;
   logic               drop_q, drop_d;
   logic               advance;

   // Physical RAM address of a logical cursor position, given the current top row.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] top,
                                                   input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      logic [ROW_W:0]   sum;
      logic [ROW_W-1:0] phys;
      sum = {1'b0, top} + {1'b0, row};
      if (sum >= (ROW_W + 1)'(ROWS)) begin
         sum = sum - (ROW_W + 1)'(ROWS);
      end
      phys = sum[ROW_W-1:0];
      return ADDR_W'(phys) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      clr_base_d = clr_base_q;
      row_d      = row_q;
      col_d      = col_q;
      top_d      = top_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = '0;
      wr_data_d  = '0;
      drop_d     = 1'b0;
      advance    = 1'b0;

      unique case (state_q)
         StInit: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_cnt_q;
            wr_data_d = BLANK;
            drop_d    = (COMMAND_IN != CMD_NULL);
            if (clr_cnt_q == ADDR_W'(CELLS - 1)) begin
               clr_cnt_d = '0;
               state_d   = StIdle;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end

         StClrRow: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_base_q + clr_cnt_q;
            wr_data_d = BLANK;
            drop_d    = (COMMAND_IN != CMD_NULL);
            if (clr_cnt_q == ADDR_W'(COLS - 1)) begin
               clr_cnt_d = '0;
               state_d   = StIdle;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end

         StIdle: begin
            unique case (COMMAND_IN)
               CMD_DISP: begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cell_addr(top_q, row_q, col_q);
                  wr_data_d = {COLOR_IN, ASCII_IN};
                  if (col_q < COL_W'(COLS - 1)) begin
                     col_d = col_q + COL_W'(1);
                  end else begin
                     col_d   = '0;
                     advance = 1'b1;
                  end
               end
               CMD_NL: begin
                  col_d   = '0;
                  advance = 1'b1;
               end
               CMD_DEL: begin
                  if (col_q != '0) begin
                     col_d     = col_q - COL_W'(1);
                     wr_en_d   = 1'b1;
                     wr_addr_d = cell_addr(top_q, row_q, col_q - COL_W'(1));
                     wr_data_d = BLANK;
                  end else if (row_q != '0) begin
                     row_d     = row_q - ROW_W'(1);
                     col_d     = COL_W'(COLS - 1);
                     wr_en_d   = 1'b1;
                     wr_addr_d = cell_addr(top_q, row_q - ROW_W'(1), COL_W'(COLS - 1));
                     wr_data_d = BLANK;
                  end
               end
               CMD_NULL: ;
            endcase

            if (advance) begin
               if (row_q < ROW_W'(ROWS - 1)) begin
                  row_d = row_q + ROW_W'(1);
               end else begin
                  // Scroll: the old top row becomes the new bottom line and is blanked.
                  top_d      = (top_q == ROW_W'(ROWS - 1)) ? '0 : top_q + ROW_W'(1);
                  clr_base_d = ADDR_W'(top_q) * ADDR_W'(COLS);
                  clr_cnt_d  = '0;
                  state_d    = StClrRow;
               end
            end
         end

         default: state_d = StInit;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StInit;
         clr_cnt_q  <= '0;
         clr_base_q <= '0;
         row_q      <= '0;
         col_q      <= '0;
         top_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b1;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         clr_base_q <= clr_base_d;
         row_q      <= row_d;
         col_q      <= col_d;
         top_q      <= top_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
      end
   end

   assign WR_EN      = wr_en_q;
   assign WR_ADDR    = wr_addr_q;
   assign WR_DATA    = wr_data_q;
   assign CURSOR_ROW = row_q;
   assign CURSOR_COL = col_q;
   assign TOP_ROW    = top_q;
   assign BUSY       = busy_q;
   assign DROP       = drop_q;

endmodule

// File: tb/tb_text_screen_writer.sv
// Directed bench for text_screen_writer: init sweep, display, wrap, scroll with drop,
// delete, and reset in the middle of the init sweep.
module tb_text_screen_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  ascii = '0;
   logic [7:0]  color = '0;
   logic [1:0]  cmd = 2'b11;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [15:0] wr_data;
   logic [4:0]  crow;
   logic [6:0]  ccol;
   logic [4:0]  top;
   logic        busy;
   logic        drop;

   int total = 0;
   int bad = 0;

   text_screen_writer dut (
      .CLK        (clk),
      .RST        (rst),
      .ASCII_IN   (ascii),
      .COLOR_IN   (color),
      .COMMAND_IN (cmd),
      .WR_EN      (wr_en),
      .WR_ADDR    (wr_addr),
      .WR_DATA    (wr_data),
      .CURSOR_ROW (crow),
      .CURSOR_COL (ccol),
      .TOP_ROW    (top),
      .BUSY       (busy),
      .DROP       (drop)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] c, input logic [7:0] a, input logic [7:0] k);
      cmd   = c;
      ascii = a;
      color = k;
      step();
      cmd = 2'b11;
   endtask

   task automatic check_reset_state(input string tag);
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b1 || drop !== 1'b0 || wr_addr !== 12'd0 ||
          wr_data !== 16'h0000) begin
         bad++;
         $display("FAIL %s_outputs got wr_en=%b busy=%b drop=%b addr=%0d data=%h want 0 1 0 0 0000",
                  tag, wr_en, busy, drop, wr_addr, wr_data);
      end
      total++;
      if (crow !== 5'd0 || ccol !== 7'd0 || top !== 5'd0) begin
         bad++;
         $display("FAIL %s_cursor got row=%0d col=%0d top=%0d want 0 0 0", tag, crow, ccol, top);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd = 2'b11;
      step();
      rst = 1'b0;
      check_reset_state("reset");
   endtask

   task automatic test_init();
      int  nw   = 0;
      int  errs = 0;
      bit  done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         step();
         if (wr_en === 1'b1) begin
            if (wr_addr !== 12'(nw) || wr_data !== 16'h0720) errs++;
            nw++;
         end
         if (busy === 1'b0) done = 1;
      end
      total++;
      if (nw !== 2400) begin
         bad++;
         $display("FAIL init_count got %0d want 2400", nw);
      end
      total++;
      if (errs !== 0) begin
         bad++;
         $display("FAIL init_sequence got %0d bad cells want 0", errs);
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL init_timeout got busy=%b want 0 within 3000 cycles", busy);
      end
      step();
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || crow !== 5'd0 || ccol !== 7'd0) begin
         bad++;
         $display("FAIL init_after got wr_en=%b busy=%b row=%0d col=%0d want 0 0 0 0",
                  wr_en, busy, crow, ccol);
      end
   endtask

   task automatic test_display();
      issue(2'b00, 8'h41, 8'h1F);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 16'h1F41 || ccol !== 7'd1) begin
         bad++;
         $display("FAIL display_a got en=%b addr=%0d data=%h col=%0d want 1 0 1f41 1",
                  wr_en, wr_addr, wr_data, ccol);
      end
      issue(2'b00, 8'h62, 8'h0A);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 12'd1 || wr_data !== 16'h0A62 || ccol !== 7'd2) begin
         bad++;
         $display("FAIL back_to_back got en=%b addr=%0d data=%h col=%0d want 1 1 0a62 2",
                  wr_en, wr_addr, wr_data, ccol);
      end
      step();
      total++;
      if (wr_en !== 1'b0 || wr_addr !== 12'd0) begin
         bad++;
         $display("FAIL single_write got en=%b addr=%0d want 0 0", wr_en, wr_addr);
      end
   endtask

   task automatic test_line_wrap();
      repeat (5) issue(2'b10, 8'h00, 8'h00);
      total++;
      if (crow !== 5'd5 || ccol !== 7'd0 || wr_en !== 1'b0) begin
         bad++;
         $display("FAIL newline got row=%0d col=%0d en=%b want 5 0 0", crow, ccol, wr_en);
      end
      repeat (79) issue(2'b00, 8'h2E, 8'h07);
      issue(2'b00, 8'h42, 8'h2C);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 12'd479 || wr_data !== 16'h2C42) begin
         bad++;
         $display("FAIL wrap_write got en=%b addr=%0d data=%h want 1 479 2c42",
                  wr_en, wr_addr, wr_data);
      end
      total++;
      if (crow !== 5'd6 || ccol !== 7'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL wrap_cursor got row=%0d col=%0d busy=%b want 6 0 0", crow, ccol, busy);
      end
   endtask

   task automatic test_scroll();
      int nw = 0;
      int errs = 0;
      int nbusy = 0;
      int ndrop = 0;
      repeat (23) issue(2'b10, 8'h00, 8'h00);
      repeat (10) issue(2'b00, 8'h30, 8'h07);
      total++;
      if (crow !== 5'd29 || ccol !== 7'd10) begin
         bad++;
         $display("FAIL scroll_setup got row=%0d col=%0d want 29 10", crow, ccol);
      end
      issue(2'b10, 8'h00, 8'h00);
      total++;
      if (crow !== 5'd29 || ccol !== 7'd0 || top !== 5'd1 || busy !== 1'b1 || wr_en !== 1'b0) begin
         bad++;
         $display("FAIL scroll_start got row=%0d col=%0d top=%0d busy=%b en=%b want 29 0 1 1 0",
                  crow, ccol, top, busy, wr_en);
      end
      nbusy = 1;
      for (int i = 0; i < 90; i++) begin
         if (i == 5) begin
            issue(2'b00, 8'h5A, 8'h4E);
            total++;
            if (drop !== 1'b1) begin
               bad++;
               $display("FAIL drop_pulse got %b want 1", drop);
            end
         end else begin
            step();
         end
         if (drop === 1'b1) ndrop++;
         if (busy === 1'b1) nbusy++;
         if (wr_en === 1'b1) begin
            if (wr_addr !== 12'(nw) || wr_data !== 16'h0720) errs++;
            nw++;
         end
      end
      total++;
      if (nw !== 80 || errs !== 0) begin
         bad++;
         $display("FAIL clear_row got writes=%0d bad=%0d want 80 0", nw, errs);
      end
      total++;
      if (nbusy !== 80) begin
         bad++;
         $display("FAIL clear_busy got %0d cycles want 80", nbusy);
      end
      total++;
      if (ndrop !== 1 || crow !== 5'd29 || ccol !== 7'd0) begin
         bad++;
         $display("FAIL drop_effect got drops=%0d row=%0d col=%0d want 1 29 0", ndrop, crow, ccol);
      end
      // Bottom line now lives in physical row 0.
      issue(2'b00, 8'h51, 8'h02);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 16'h0251 || ccol !== 7'd1) begin
         bad++;
         $display("FAIL post_scroll got en=%b addr=%0d data=%h col=%0d want 1 0 0251 1",
                  wr_en, wr_addr, wr_data, ccol);
      end
   endtask

   task automatic test_mid_init_reset();
      int nw = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 1500 && nw < 1000; i++) begin
         step();
         if (wr_en === 1'b1) nw++;
      end
      total++;
      if (nw !== 1000 || busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_init_count got writes=%0d busy=%b want 1000 1", nw, busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state("mid_init_reset");
      test_init();
   endtask

   task automatic test_delete();
      issue(2'b01, 8'h00, 8'h00);
      total++;
      if (wr_en !== 1'b0 || drop !== 1'b0 || crow !== 5'd0 || ccol !== 7'd0) begin
         bad++;
         $display("FAIL delete_home got en=%b drop=%b row=%0d col=%0d want 0 0 0 0",
                  wr_en, drop, crow, ccol);
      end
      repeat (3) issue(2'b10, 8'h00, 8'h00);
      issue(2'b01, 8'h00, 8'h00);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 12'd239 || wr_data !== 16'h0720 ||
          crow !== 5'd2 || ccol !== 7'd79) begin
         bad++;
         $display("FAIL delete_row got en=%b addr=%0d data=%h row=%0d col=%0d want 1 239 0720 2 79",
                  wr_en, wr_addr, wr_data, crow, ccol);
      end
      issue(2'b01, 8'h00, 8'h00);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 12'd238 || ccol !== 7'd78) begin
         bad++;
         $display("FAIL delete_col got en=%b addr=%0d col=%0d want 1 238 78", wr_en, wr_addr, ccol);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_display();
      test_line_wrap();
      test_scroll();
      test_mid_init_reset();
      test_delete();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
